// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with status flags, occupancy count,
// sticky overflow/underflow errors, synchronous flush and optional
// first-word-fall-through read mode.
module fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AE_THRESH  = 1,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int FWFT       = 0
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    clear,
  input  logic                    write_enb,
  input  logic                    read_enb,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Flags decode the registered count only, so they never glitch mid-cycle.
  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  // A full FIFO refuses writes and an empty one refuses reads even if the
  // opposite operation would free/fill a slot in the same cycle.
  assign w_wr_acc = write_enb && !w_full;
  assign w_rd_acc = read_enb && !w_empty;

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_empty = (r_count <= AE_C);
  assign almost_full  = (r_count >= AF_C);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Storage array: written on accepted writes, deliberately never reset.
  always_ff @(posedge clock) begin
    if (!clear && w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointer, occupancy and sticky error bookkeeping; clear outranks everything.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + CW'(1);
      else if (w_rd_acc && !w_wr_acc) r_count <= r_count - CW'(1);
      if (write_enb && w_full)  r_overflow  <= 1'b1;
      if (read_enb && w_empty)  r_underflow <= 1'b1;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_WIDTH-1:0] r_data_out;

      // Registered read port: loads on accepted reads, otherwise holds.
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          r_data_out <= '0;
        end else if (clear) begin
          r_data_out <= '0;
        end else if (w_rd_acc) begin
          r_data_out <= r_mem[r_rd_ptr];
        end
      end

      assign data_out = r_data_out;
    end else begin : g_fwft
      // Head word is shown directly; read_enb only acknowledges it.
      assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];
    end
  endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// Directed scoreboard bench for fifo_param: a standard-mode instance (A)
// with read data checked by a decoupled monitor, and an FWFT instance (B).
module tb_fifo_param;

  logic       clock = 1'b0;
  logic       resetn;

  // Instance A: FWFT=0
  logic       a_clear, a_we, a_re;
  logic [7:0] a_din, a_dout;
  logic       a_full, a_empty, a_ae, a_af, a_ovf, a_unf;
  logic [4:0] a_count;

  // Instance B: FWFT=1
  logic       b_clear, b_we, b_re;
  logic [7:0] b_din, b_dout;
  logic       b_full, b_empty, b_ae, b_af, b_ovf, b_unf;
  logic [4:0] b_count;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] q_exp [$];
  logic mon_pend = 1'b0;

  fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AE_THRESH(1), .AF_THRESH(15), .FWFT(0)) u_a (
    .clock(clock), .resetn(resetn), .clear(a_clear),
    .write_enb(a_we), .read_enb(a_re), .data_in(a_din), .data_out(a_dout),
    .full(a_full), .empty(a_empty), .almost_empty(a_ae), .almost_full(a_af),
    .count(a_count), .overflow(a_ovf), .underflow(a_unf)
  );

  fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AE_THRESH(1), .AF_THRESH(15), .FWFT(1)) u_b (
    .clock(clock), .resetn(resetn), .clear(b_clear),
    .write_enb(b_we), .read_enb(b_re), .data_in(b_din), .data_out(b_dout),
    .full(b_full), .empty(b_empty), .almost_empty(b_ae), .almost_full(b_af),
    .count(b_count), .overflow(b_ovf), .underflow(b_unf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: an accepted standard-mode read presents data in the next cycle.
  always @(posedge clock) mon_pend <= resetn && !a_clear && a_re && !a_empty;

  always @(negedge clock) begin
    if (mon_pend) begin : mon_cmp
      logic [7:0] e;
      if (q_exp.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_data: got %02h, expected no read (t=%0t)", a_dout, $time);
      end else begin
        e = q_exp.pop_front();
        chk("rd_data", a_dout, e);
      end
    end
  end

  task automatic tick_a(input logic we, input logic re, input logic [7:0] d);
    a_we = we; a_re = re; a_din = d;
    @(posedge clock); #1;
    a_we = 1'b0; a_re = 1'b0;
  endtask

  task automatic rd_a(input logic [7:0] e);
    q_exp.push_back(e);
    tick_a(1'b0, 1'b1, 8'h00);
  endtask

  task automatic tick_b(input logic we, input logic re, input logic [7:0] d);
    b_we = we; b_re = re; b_din = d;
    @(posedge clock); #1;
    b_we = 1'b0; b_re = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    logic [7:0] wv, rv;
    resetn = 1'b0;
    a_clear = 0; a_we = 0; a_re = 0; a_din = 0;
    b_clear = 0; b_we = 0; b_re = 0; b_din = 0;
    #2;
    chk("rst_count", a_count, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_ae", a_ae, 1);
    chk("rst_full", a_full, 0);
    chk("rst_af", a_af, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_unf", a_unf, 0);
    chk("rst_dout", a_dout, 0);
    chk("rst_b_empty", b_empty, 1);
    chk("rst_b_dout", b_dout, 0);
    @(posedge clock); #1;
    resetn = 1'b1;

    // Mid-burst asynchronous reset
    for (int i = 0; i < 5; i++) tick_a(1'b1, 1'b0, 8'h21 + 8'(i));
    chk("pre_rst_count", a_count, 5);
    rd_a(8'h21);
    #6;
    resetn = 1'b0;
    #1;
    chk("async_count", a_count, 0);
    chk("async_empty", a_empty, 1);
    chk("async_ae", a_ae, 1);
    chk("async_full", a_full, 0);
    chk("async_ovf", a_ovf, 0);
    chk("async_dout", a_dout, 0);
    @(posedge clock); #1;
    resetn = 1'b1;

    // Fill and overflow
    for (int i = 0; i < 15; i++) tick_a(1'b1, 1'b0, 8'(i));
    chk("fill15_count", a_count, 15);
    chk("fill15_af", a_af, 1);
    chk("fill15_full", a_full, 0);
    tick_a(1'b1, 1'b0, 8'h0F);
    chk("fill16_full", a_full, 1);
    chk("fill16_ovf", a_ovf, 0);
    tick_a(1'b1, 1'b0, 8'hAA);
    chk("ovf_count", a_count, 16);
    chk("ovf_flag", a_ovf, 1);
    for (int i = 0; i < 16; i++) rd_a(8'(i));
    chk("drain_empty", a_empty, 1);
    chk("drain_unf", a_unf, 0);

    // Underflow with simultaneous write on empty
    tick_a(1'b1, 1'b1, 8'h55);
    chk("unf_flag", a_unf, 1);
    chk("unf_count", a_count, 1);
    chk("unf_dout_hold", a_dout, 8'h0F);
    rd_a(8'h55);
    chk("unf_drain_count", a_count, 0);

    // Simultaneous read/write at count 5
    for (int i = 0; i < 5; i++) tick_a(1'b1, 1'b0, 8'h01 + 8'(i));
    for (int j = 0; j < 20; j++) begin
      q_exp.push_back((j < 5) ? 8'(j + 1) : 8'h11);
      tick_a(1'b1, 1'b1, 8'h11);
      chk("simul_count", a_count, 5);
      chk("simul_ae", a_ae, 0);
      chk("simul_af", a_af, 0);
    end
    for (int i = 0; i < 5; i++) rd_a(8'h11);
    chk("simul_drain", a_count, 0);

    // Wrap-around with interleaved traffic
    wv = 8'h80; rv = 8'h80; cnt = 0;
    for (int i = 0; i < 2; i++) begin tick_a(1'b1, 1'b0, wv); wv++; cnt++; end
    for (int k = 0; k < 38; k++) begin
      if (k % 4 == 1) begin
        tick_a(1'b1, 1'b0, wv);
        cnt++;
      end else begin
        q_exp.push_back(rv); rv++;
        tick_a(1'b1, 1'b1, wv);
      end
      wv++;
      chk("wrap_count", a_count, cnt);
      chk("wrap_full", a_full, 0);
      chk("wrap_empty", a_empty, 0);
    end
    while (cnt > 0) begin rd_a(rv); rv++; cnt--; end
    chk("wrap_end_empty", a_empty, 1);

    // Standard-mode clear zeroes the read register
    tick_a(1'b1, 1'b0, 8'h77);
    a_clear = 1'b1;
    tick_a(1'b0, 1'b1, 8'h00);
    a_clear = 1'b0;
    chk("a_clr_dout", a_dout, 0);
    chk("a_clr_count", a_count, 0);

    // FWFT instance
    tick_b(1'b1, 1'b0, 8'h3C);
    chk("fwft_show", b_dout, 8'h3C);
    chk("fwft_nonempty", b_empty, 0);
    tick_b(1'b0, 1'b1, 8'h00);
    chk("fwft_pop_empty", b_empty, 1);
    chk("fwft_pop_dout", b_dout, 0);
    for (int i = 0; i < 16; i++) tick_b(1'b1, 1'b0, 8'h40 + 8'(i));
    chk("fwft_full", b_full, 1);
    tick_b(1'b1, 1'b0, 8'hEE);
    chk("fwft_ovf", b_ovf, 1);
    for (int i = 0; i < 8; i++) begin
      chk("fwft_head", b_dout, 8'h40 + i);
      tick_b(1'b0, 1'b1, 8'h00);
    end
    chk("fwft_count8", b_count, 8);
    chk("fwft_head8", b_dout, 8'h48);
    b_clear = 1'b1;
    tick_b(1'b1, 1'b0, 8'h99);
    b_clear = 1'b0;
    chk("clr_count", b_count, 0);
    chk("clr_ovf", b_ovf, 0);
    chk("clr_empty", b_empty, 1);
    chk("clr_dout", b_dout, 0);
    tick_b(1'b1, 1'b0, 8'h5A);
    chk("post_clr_dout", b_dout, 8'h5A);
    chk("post_clr_count", b_count, 1);

    @(posedge clock); #1;
    chk("sb_leftover", q_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
